// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: streams message words into hasher memory, appends SHA-256
// padding and length, then starts the hasher and waits for it to finish.
module sha256_msg_padder #(
    parameter int MAX_BLOCKS = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        hash_start,
    output logic [7:0]  num_blocks,
    input  logic        hash_done,
    output logic        busy,
    output logic        overflow
);
    localparam logic [15:0] CAP = 16'(16 * MAX_BLOCKS - 3);

    typedef enum logic [2:0] {IDLE, LOAD, PAD, START, WAIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] base_q, base_d, n_q, n_d, idx_q, idx_d;
    logic [15:0] addr_q, addr_d, last_idx;
    logic [31:0] data_q, data_d;
    logic [7:0]  nb_q, nb_d, blocks;
    logic        we_q, we_d, start_q, start_d, busy_q, busy_d, ovf_q, ovf_d;
    logic        hs;

    assign in_ready       = (state_q == IDLE || state_q == LOAD) && !reset;
    assign hs             = in_valid && in_ready;
    // Blocks needed for N words plus marker and 64-bit length: ceil((N+3)/16).
    assign blocks         = 8'((n_q + 16'd18) >> 4);
    assign last_idx       = {4'b0, blocks, 4'b0} - 16'd1;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = data_q;
    assign hash_start     = start_q;
    assign num_blocks     = nb_q;
    assign busy           = busy_q;
    assign overflow       = ovf_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        n_d     = n_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        nb_d    = nb_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        start_d = 1'b0;
        case (state_q)
            IDLE: if (hs) begin
                base_d  = base_addr;
                n_d     = 16'd1;
                idx_d   = 16'd1;
                ovf_d   = 1'b0;
                busy_d  = 1'b1;
                we_d    = 1'b1;
                addr_d  = base_addr;
                data_d  = in_data;
                state_d = in_last ? PAD : LOAD;
            end
            LOAD: if (hs) begin
                if (n_q == CAP) begin
                    ovf_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    addr_d = base_q + n_q;
                    data_d = in_data;
                    n_d    = n_q + 16'd1;
                    idx_d  = n_q + 16'd1;
                end
                if (in_last) state_d = PAD;
            end
            PAD: begin
                we_d    = 1'b1;
                addr_d  = base_q + idx_q;
                data_d  = idx_q == n_q      ? 32'h8000_0000 :
                          idx_q == last_idx ? {11'b0, n_q, 5'b0} : 32'h0;
                idx_d   = idx_q + 16'd1;
                state_d = idx_q == last_idx ? START : PAD;
            end
            START: begin
                start_d = 1'b1;
                nb_d    = blocks;
                state_d = WAIT;
            end
            WAIT: if (hash_done) begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            nb_q    <= '0;
            we_q    <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            nb_q    <= nb_d;
            we_q    <= we_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: table-driven jobs with hand-computed padding results,
// plus hand sequences for WAIT hold-off, idle hash_done and reset during padding.
module tb_sha256_msg_padder;
    logic        clk = 0, reset = 1;
    logic [15:0] base_addr = '0;
    logic        in_valid = 0, in_last = 0, hash_done = 0;
    logic [31:0] in_data = '0;
    logic        in_ready, mem_we, hash_start, busy, overflow;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [7:0]  num_blocks;

    sha256_msg_padder dut (
        .clk(clk), .reset(reset), .base_addr(base_addr), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .hash_start(hash_start),
        .num_blocks(num_blocks), .hash_done(hash_done), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sent;
        int          n;
        logic [15:0] base;
        logic [31:0] seed;
        int          gaps;
        int          blocks;
        logic [31:0] len;
        logic        ovf;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t  wq[$];
    vec_t tbl[7];
    int   cyc = 0, start_cnt = 0, nvec = 0, nmis = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we) wq.push_back('{mem_addr, mem_write_data});
        if (hash_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int k = 0;
        in_valid = 1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) chk("ready_timeout", {31'b0, in_ready}, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic run_job(input vec_t v);
        int          t_last, k;
        bit          ok;
        logic [31:0] ed;
        wq.delete();
        for (int i = 0; i < v.sent; i++) begin
            if (v.gaps != 0) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            base_addr = (i == 0) ? v.base : 16'h5A5A;
            push(v.seed + i, i == v.sent - 1);
            if (i == 0) begin
                chk("ovf_clear", {31'b0, overflow}, 0);
                chk("busy_set", {31'b0, busy}, 1);
            end
        end
        t_last = cyc;
        k = 0;
        while (!hash_start && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("start_seen", {31'b0, hash_start}, 1);
        chk("latency", cyc - t_last, 16 * v.blocks - v.n + 1);
        chk("num_blocks", {24'b0, num_blocks}, v.blocks);
        chk("overflow", {31'b0, overflow}, {31'b0, v.ovf});
        chk("ready_in_start", {31'b0, in_ready}, 0);
        chk("we_in_start", {31'b0, mem_we}, 0);
        chk("write_count", wq.size(), 16 * v.blocks);
        for (int j = 0; j < wq.size() && j < 16 * v.blocks; j++) begin
            ed = j < v.n ? v.seed + j : j == v.n ? 32'h8000_0000 :
                 j == 16 * v.blocks - 1 ? v.len : 32'h0;
            chk($sformatf("wr_addr[%0d]", j), {16'b0, wq[j].a}, {16'b0, v.base + 16'(j)});
            chk($sformatf("wr_data[%0d]", j), wq[j].d, ed);
        end
        ok = 1;
        repeat (v.hold) begin
            @(negedge clk);
            if (in_ready !== 0 || busy !== 1 || hash_start !== 0) ok = 0;
        end
        chk("wait_hold", {31'b0, ok}, 1);
        chk("no_wait_writes", wq.size(), 16 * v.blocks);
        @(posedge clk);
        #1 hash_done = 1;
        @(posedge clk);
        #1 hash_done = 0;
        chk("done_ready", {31'b0, in_ready}, 1);
        chk("done_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        int s0;
        tbl[0] = '{1,  1,  16'h0100, 32'hDEADBEEF, 0, 1, 32'h20,  1'b0, 50};
        tbl[1] = '{13, 13, 16'h0000, 32'h0000_0000, 0, 1, 32'h1A0, 1'b0, 2};
        tbl[2] = '{14, 14, 16'h0000, 32'h0000_0000, 0, 2, 32'h1C0, 1'b0, 2};
        tbl[3] = '{20, 20, 16'h0000, 32'h0000_0000, 1, 2, 32'h280, 1'b0, 3};
        tbl[4] = '{2,  2,  16'hFFFE, 32'hCAFE_0000, 1, 1, 32'h40,  1'b0, 2};
        tbl[5] = '{31, 29, 16'h0000, 32'h0000_0100, 0, 2, 32'h3A0, 1'b1, 2};
        tbl[6] = '{29, 29, 16'h0040, 32'h7700_0000, 0, 2, 32'h3A0, 1'b0, 2};

        #2;
        chk("rst_ready", {31'b0, in_ready}, 0);
        chk("rst_we", {31'b0, mem_we}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_start", {31'b0, hash_start}, 0);
        chk("rst_nb", {24'b0, num_blocks}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(posedge clk);
        #1 chk("post_rst_ready", {31'b0, in_ready}, 1);

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i]);
            if (i == 0) begin
                s0 = start_cnt;
                hash_done = 1;
                repeat (3) @(posedge clk);
                #1;
                chk("idle_done_ready", {31'b0, in_ready}, 1);
                chk("idle_done_busy", {31'b0, busy}, 0);
                chk("idle_done_nostart", start_cnt, s0);
                hash_done = 0;
            end
        end

        wq.delete();
        s0 = start_cnt;
        base_addr = 16'h0200;
        push(32'h1234_5678, 1);
        repeat (3) @(posedge clk);
        #1 chk("in_pad", {31'b0, mem_we}, 1);
        #1 reset = 1;
        #1;
        chk("mid_rst_we", {31'b0, mem_we}, 0);
        chk("mid_rst_ready", {31'b0, in_ready}, 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        chk("mid_rst_nb", {24'b0, num_blocks}, 0);
        chk("mid_rst_addr", {16'b0, mem_addr}, 0);
        @(posedge clk);
        #1 reset = 0;
        repeat (40) @(posedge clk);
        #1 chk("mid_rst_nostart", start_cnt, s0);
        run_job(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
